// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the register file's single write port between two writeback
//   sources and tracks registers with outstanding multi-cycle results.
//
//   Requester A : in-order pipeline writeback (normally wins).
//   Requester B : multi-cycle unit writeback. B takes priority once it has
//                 been denied MAX_WAIT consecutive cycles while valid.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   a_valid/a_waddr/a_wdata       A writeback request
//   a_ready                       A granted this cycle (combinational)
//   b_valid/b_waddr/b_wdata       B writeback request
//   b_ready                       B granted this cycle (combinational)
//   b_issue/b_issue_rd            B op issued; mark its destination pending
//   raddr1/raddr2                 decode read addresses (hazard query)
//   stall                         decode must stall (combinational)
//   rfwrite/waddr/wdata           registered register-file write port
//   err_dup                       sticky: issue to an already-pending reg
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Ready is a function of valid (at most one grant per cycle), so a source
// must hold valid/addr/data stable until it sees ready. Ready and stall
// are held low while rst is high.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  input  logic        b_issue,
  input  logic [4:0]  b_issue_rd,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        stall,
  output logic        rfwrite,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        err_dup
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic        rfwrite_q, rfwrite_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_dup_q, err_dup_d;
  logic [31:0] pending_q, pending_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic prio_b, grant_a, grant_b;
  logic hz1, hz2;
  logic issue_en, issue_dup;

  // Arbitration: B first only after it has starved MAX_WAIT cycles.
  always_comb begin
    prio_b  = (wait_cnt_q == MAX_W);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (prio_b && b_valid)  grant_b = 1'b1;
      else if (a_valid)       grant_a = 1'b1;
      else if (b_valid)       grant_b = 1'b1;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // A read hazard exists while the register is pending, and also in the
  // cycle its B result sits in the write register but not yet the array.
  always_comb begin
    hz1 = (raddr1 != 5'd0) &&
          (pending_q[raddr1] || (rfwrite_q && (waddr_q == raddr1)));
    hz2 = (raddr2 != 5'd0) &&
          (pending_q[raddr2] || (rfwrite_q && (waddr_q == raddr2)));
  end

  assign stall = !rst && (hz1 || hz2);

  always_comb begin
    // Write path: hold address/data when nothing is granted.
    rfwrite_d = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    if (grant_a) begin
      rfwrite_d = (a_waddr != 5'd0);
      waddr_d   = a_waddr;
      wdata_d   = a_wdata;
    end else if (grant_b) begin
      rfwrite_d = (b_waddr != 5'd0);
      waddr_d   = b_waddr;
      wdata_d   = b_wdata;
    end

    // Starvation counter saturates at MAX_WAIT.
    wait_cnt_d = 4'd0;
    if (b_valid && !grant_b) begin
      wait_cnt_d = (wait_cnt_q == MAX_W) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end

    // Scoreboard: the clear is applied before the set so a same-cycle
    // issue to the retiring register leaves the newer op outstanding.
    issue_en  = b_issue && (b_issue_rd != 5'd0);
    issue_dup = issue_en && pending_q[b_issue_rd] &&
                !(grant_b && (b_waddr == b_issue_rd));
    pending_d = pending_q;
    if (grant_b)  pending_d[b_waddr]    = 1'b0;
    if (issue_en) pending_d[b_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;

    err_dup_d = err_dup_q || issue_dup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rfwrite_q  <= 1'b0;
      waddr_q    <= 5'd0;
      wdata_q    <= 32'd0;
      err_dup_q  <= 1'b0;
      pending_q  <= 32'd0;
      wait_cnt_q <= 4'd0;
    end else begin
      rfwrite_q  <= rfwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_dup_q  <= err_dup_d;
      pending_q  <= pending_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign rfwrite = rfwrite_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign err_dup = err_dup_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int MAX_WAIT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, b_issue;
  logic [4:0]  a_waddr, b_waddr, b_issue_rd, raddr1, raddr2;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ready, b_ready, stall, rfwrite, err_dup;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_ready(a_ready),
    .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
    .b_issue(b_issue), .b_issue_rd(b_issue_rd),
    .raddr1(raddr1), .raddr2(raddr2), .stall(stall),
    .rfwrite(rfwrite), .waddr(waddr), .wdata(wdata), .err_dup(err_dup)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Denied-cycle counter, set of outstanding B destinations, and the last
  // write presented to the register file.
  int          m_denied;
  bit          m_pend[32];
  bit          m_we, m_err, m_ok = 1'b0;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic bit m_b_wins();
    if (rst || !b_valid) return 1'b0;
    return (m_denied >= MAX_WAIT) || !a_valid;
  endfunction

  function automatic bit m_hazard(input logic [4:0] r);
    if (rst || r == 5'd0) return 1'b0;
    return m_pend[r] || (m_we && m_addr == r);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_denied = 0; m_we = 0; m_addr = '0; m_data = '0; m_err = 0; m_ok = 1'b1;
    end else begin
      bit bw, aw;
      bw = m_b_wins();
      aw = a_valid && !bw;
      if (aw) begin
        m_we = (a_waddr != 0); m_addr = a_waddr; m_data = a_wdata;
      end else if (bw) begin
        m_we = (b_waddr != 0); m_addr = b_waddr; m_data = b_wdata;
      end else m_we = 1'b0;
      if (b_issue && b_issue_rd != 0 && m_pend[b_issue_rd] && !(bw && b_waddr == b_issue_rd))
        m_err = 1'b1;
      if (bw) m_pend[b_waddr] = 1'b0;
      if (b_issue && b_issue_rd != 0) m_pend[b_issue_rd] = 1'b1;
      if (b_valid && !bw) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
      else m_denied = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      bit bw;
      bw = m_b_wins();
      chk("a_ready", a_ready, a_valid && !bw && !rst);
      chk("b_ready", b_ready, bw);
      chk("stall",   stall,   m_hazard(raddr1) || m_hazard(raddr2));
      chk("rfwrite", rfwrite, m_we);
      chk("waddr",   waddr,   m_addr);
      chk("wdata",   wdata,   m_data);
      chk("err_dup", err_dup, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; b_issue = 0;
    a_waddr = 0; b_waddr = 0; b_issue_rd = 0;
    a_wdata = 0; b_wdata = 0; raddr1 = 0; raddr2 = 0;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    logic [5:0] pat;
    idle_inputs();
    rst = 1; a_valid = 1; a_waddr = 5'd5; a_wdata = 32'h1234;

    // Reset held 2 cycles with A requesting.
    #1 chk("rst_a_ready", a_ready, 1'b0);
    cyc(); cyc();
    chk("rst_rfwrite", rfwrite, 1'b0);
    chk("rst_waddr",   waddr,   5'd0);
    chk("rst_wdata",   wdata,   32'd0);
    chk("rst_err",     err_dup, 1'b0);
    rst = 0; idle_inputs();
    for (int r = 1; r < 32; r += 5) begin
      raddr1 = 5'(r); #1 chk("rst_stall", stall, 1'b0);
    end
    raddr1 = 0;
    cyc();

    // A only, then A to x0.
    a_valid = 1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
    #1 chk("a_ready", a_ready, 1'b1);
    cyc();
    chk("a_rfwrite", rfwrite, 1'b1);
    chk("a_waddr",   waddr,   5'd5);
    chk("a_wdata",   wdata,   32'hDEADBEEF);
    a_waddr = 5'd0;
    #1 chk("a0_ready", a_ready, 1'b1);
    cyc();
    chk("a0_rfwrite", rfwrite, 1'b0);
    a_valid = 0;
    cyc();
    chk("idle_rfwrite", rfwrite, 1'b0);

    // Starvation: A wins 4 cycles, B on the 5th, A again.
    a_valid = 1; a_waddr = 5'd1; a_wdata = 32'hAAAA0001;
    b_valid = 1; b_waddr = 5'd10; b_wdata = 32'hBBBB0010;
    pat = 6'b101111;  // bit i = A granted in cycle i
    for (int i = 0; i < 6; i++) begin
      #1 chk("starve_a", a_ready, pat[i]);
      chk("starve_b", b_ready, !pat[i]);
      cyc();
      if (i == 4) begin
        chk("starve_bw_addr", waddr, 5'd10);
        chk("starve_bw_data", wdata, 32'hBBBB0010);
      end
    end
    idle_inputs();
    cyc();

    // Scoreboard: issue rd=7, hazard until the write lands.
    b_issue = 1; b_issue_rd = 5'd7;
    cyc();
    b_issue = 0; raddr1 = 5'd7;
    #1 chk("sb_stall_pend", stall, 1'b1);
    cyc();
    b_valid = 1; b_waddr = 5'd7; b_wdata = 32'h00000077;
    #1 chk("sb_b_ready", b_ready, 1'b1);
    cyc();
    b_valid = 0;
    #1 chk("sb_stall_wr", stall, 1'b1);
    chk("sb_rfwrite", rfwrite, 1'b1);
    cyc();
    chk("sb_stall_clr", stall, 1'b0);
    raddr1 = 0;

    // Simultaneous issue and retire of rd=9.
    b_issue = 1; b_issue_rd = 5'd9;
    cyc();
    b_valid = 1; b_waddr = 5'd9; b_wdata = 32'h99;
    cyc();
    idle_inputs(); raddr2 = 5'd9;
    cyc();
    chk("sim_pend9", stall, 1'b1);
    chk("sim_err", err_dup, 1'b0);
    b_issue = 1; b_issue_rd = 5'd9;
    cyc();
    b_issue = 0;
    chk("dup_err", err_dup, 1'b1);
    repeat (3) cyc();
    chk("dup_sticky", err_dup, 1'b1);
    // Issue to x0 is ignored.
    b_issue = 1; b_issue_rd = 5'd0;
    cyc();
    idle_inputs();

    // Reset mid-operation: pending[3], wait count 3, then rst.
    b_issue = 1; b_issue_rd = 5'd3;
    cyc();
    b_issue = 0;
    a_valid = 1; a_waddr = 5'd2; a_wdata = 32'h22;
    b_valid = 1; b_waddr = 5'd4; b_wdata = 32'h44;
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0; raddr1 = 5'd3;
    chk("mid_err", err_dup, 1'b0);
    chk("mid_rfwrite", rfwrite, 1'b0);
    #1 chk("mid_stall", stall, 1'b0);
    pat = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("mid_a", a_ready, pat[i]);
      chk("mid_b", b_ready, !pat[i]);
      cyc();
    end
    idle_inputs();
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - Requester A: the in-order pipeline writeback.
  - Requester B: the multi-cycle unit (load/mul-div) writeback.
- Keeps a scoreboard of registers with outstanding B writes and raises a read-hazard stall for the decode stage.
- Sits between the writeback sources and the register file; drives its rfwrite/waddr/wdata.

Parameters:
- MAX_WAIT, 4: consecutive cycles B may be denied while valid before it takes priority (1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  A has a writeback pending
- a_waddr  in  5  A destination register
- a_wdata  in  32  A write data
- a_ready  out  1  A granted this cycle (combinational)
- b_valid  in  1  B has a writeback pending
- b_waddr  in  5  B destination register
- b_wdata  in  32  B write data
- b_ready  out  1  B granted this cycle (combinational)
- b_issue  in  1  B operation issued; mark destination pending
- b_issue_rd  in  5  destination of issued B operation
- raddr1  in  5  decode read address 1 (hazard query)
- raddr2  in  5  decode read address 2 (hazard query)
- stall  out  1  decode must stall (combinational)
- rfwrite  out  1  register file write enable (registered)
- waddr  out  5  register file write address (registered)
- wdata  out  32  register file write data (registered)
- err_dup  out  1  sticky: b_issue to an already-pending register

Behaviour:
- Reset (rst=1 at posedge):
  - rfwrite=0, waddr=0, wdata=0, err_dup=0.
  - pending[31:0]=0, wait_cnt=0.
  - a_ready/b_ready follow the arbitration rules below; outputs are forced low while rst=1.
- Reset mid-operation discards any granted-but-unwritten data and all pending bits. No partial writes.
- Arbitration (combinational, one grant per cycle max):
  - prio_b = (wait_cnt == MAX_WAIT).
  - If prio_b and b_valid: grant B.
  - Else if a_valid: grant A.
  - Else if b_valid: grant B.
  - a_ready = grant_a; b_ready = grant_b. Ready depends on valid.
  - A source must hold valid/addr/data stable until ready.
- wait_cnt:
  - b_valid & !grant_b: increment, saturating at MAX_WAIT.
  - grant_b or !b_valid: clear to 0.
- Write path, 1-cycle latency:
  - On the grant edge, register waddr/wdata from the winner.
  - rfwrite = granted & (winner addr != 0).
  - Writes to x0 complete the handshake but never assert rfwrite.
  - No grant: rfwrite=0, waddr/wdata hold their last values.
- Scoreboard:
  - b_issue & b_issue_rd!=0 sets pending[b_issue_rd].
  - grant_b clears pending[b_waddr].
  - Issue and grant to the same rd in the same cycle: set wins (the newer op remains outstanding).
  - b_issue to x0: ignored.
  - b_issue to a register already pending (not cleared that cycle): set err_dup=1, sticky until rst.
  - pending[0] is always 0.
- Stall:
  - stall = hz(raddr1) | hz(raddr2).
  - hz(r) = (r!=0) & (pending[r] | (rfwrite & waddr==r)).
  - The second term covers the cycle in which a registered write has not yet reached the array.
  - A-side hazards are outside this block: the pipeline forwards them.
- Grants do not depend on stall. A and B addresses may collide; order is grant order.

Test Plan:
- Reset: assert rst 2 cycles with a_valid=1 -> rfwrite=0, waddr=0, wdata=0, err_dup=0, stall=0, pending all 0.
- A only:
  - Stimulus: a_valid=1, a_waddr=5, a_wdata=0xDEADBEEF.
  - Response: a_ready=1 same cycle. Next cycle rfwrite=1, waddr=5, wdata=0xDEADBEEF.
  - Then a_waddr=0: a_ready=1, next cycle rfwrite=0.
- Starvation (MAX_WAIT=4):
  - Stimulus: a_valid and b_valid held high.
  - Response: A granted cycles 0-3; B granted cycle 4 (b_ready=1, a_ready=0); A granted cycle 5; wait_cnt restarts.
- Scoreboard:
  - b_issue rd=7, then raddr1=7 -> stall=1.
  - B granted with b_waddr=7: stall stays 1 the next cycle (rfwrite & waddr==7), then 0.
- Simultaneous issue/clear:
  - Stimulus: grant_b with b_waddr=9 while b_issue rd=9 in the same cycle.
  - Response: pending[9]=1 afterwards, err_dup=0.
  - A second b_issue rd=9 -> err_dup=1 and stays 1 until rst.
- Reset mid-operation:
  - Stimulus: pending[3]=1, wait_cnt=3, rst pulsed.
  - Response: stall=0 for raddr1=3; B then waits a full MAX_WAIT cycles before getting priority.
